// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI receive slave.
package spi_pkg;
   localparam int SPI_MODE       = 0;
   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_state_e;
endpackage

// File: rtl/spi_slave_rx_if.sv
// Pin-level SPI lines plus the received-word stream and status flags.
interface spi_slave_rx_if
   import spi_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);
   logic              spi_sclk;
   logic              spi_ss_n;
   logic              spi_mosi;
   logic              spi_miso;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              overrun;
   logic              frame_err;
   logic [7:0]        word_count;

   modport slave (
      input  spi_sclk, spi_ss_n, spi_mosi, rx_ready,
      output spi_miso, rx_data, rx_valid, overrun, frame_err, word_count
   );

   modport master (
      output spi_sclk, spi_ss_n, spi_mosi, rx_ready,
      input  spi_miso, rx_data, rx_valid, overrun, frame_err, word_count
   );
endinterface

// File: rtl/spi_rx_fifo.sv
// Small first-word-fall-through buffer; head reads as zero while empty.
module spi_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [DATA_W-1:0] rdata_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              push_ok;
   logic              pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i && !empty_o;
   // A full buffer still accepts a push when a pop frees a slot in the same cycle.
   assign push_ok = push_i && (!full_o || pop_ok);
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI receive-only slave: synchronizes the pins, deserializes words MSB first
// and queues them for a valid/ready consumer.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   spi_slave_rx_if.slave bus
);
   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] flush_q;
   logic                   sclk_prev_q;
   logic                   armed_q;
   logic                   sclk_s, ss_s, mosi_s, sclk_rise;

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q;
   logic [7:0]        word_cnt_q;
   logic              push, pop, fifo_full, fifo_empty;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s && !sclk_prev_q;

   // flush_q marks when the synchronizers hold real pin samples rather than reset
   // values, so a select held low across reset cannot start a word.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         flush_q     <= '0;
         sclk_prev_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
         flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         sclk_prev_q <= sclk_s;
         if (flush_q[SYNC_STAGES-1] && ss_s) armed_q <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (armed_q && !ss_s) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (ss_s) begin
               state_d     = ST_IDLE;
               frame_err_d = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
            end else if (sclk_rise) begin
               shift_d = {shift_q[DATA_W-2:0], mosi_s};
               if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
                  push      = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         if (push && fifo_full && !pop) overrun_q <= 1'b1;
         if (push && (!fifo_full || pop)) word_cnt_q <= word_cnt_q + 1'b1;
      end
   end

   assign pop = !fifo_empty && bus.rx_ready;

   spi_rx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLOCK_50),
      .srst    (reset),
      .push_i  (push),
      .wdata_i (shift_d),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .rdata_o (bus.rx_data)
   );

   assign bus.rx_valid   = !fifo_empty;
   assign bus.overrun    = overrun_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.word_count = word_cnt_q;
   assign bus.spi_miso   = 1'b0;
endmodule
